// File: rtl/l2_conv_pkg.sv
// Shared layer-2 conv definitions: FSM encoding and default geometry, common to
// the input-side and output-side controllers.
package l2_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    localparam int unsigned L2_DW     = 16;
    localparam int unsigned L2_COL_N  = 12;
    localparam int unsigned L2_ROW_N  = 24;
    localparam int unsigned L2_CH_N   = 8;
    localparam int unsigned L2_OUT_AW = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_pool_rowbuf.sv
// Row buffer for vertical max-pool: one horizontal-max entry per pooled column.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents need no reset: every entry is written on an even row before the odd
// row reads it.
module l2_pool_rowbuf
    import l2_conv_pkg::*;
#(
    parameter int unsigned DW    = L2_DW,
    parameter int unsigned DEPTH = L2_COL_N / 2,
    parameter int unsigned AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/l2_conv_out_ctrl.sv
// Layer-2 conv output controller: ReLU + 2x2/stride-2 max-pool on the raster
// stream (col, row, channel) and sequential writes to the output RAM.
// Ports: clk, rstn; ConvValid_i run enable; vbit_i/ConvData_i conv stream;
// OutRamWe_o/OutRamAddr_o/OutRamData_o RAM write; Busy_o (RUN), Done_o (DONE),
// Err_o sticky "sample seen outside RUN".
module l2_conv_out_ctrl
    import l2_conv_pkg::*;
#(
    parameter int unsigned DW     = L2_DW,
    parameter int unsigned COL_N  = L2_COL_N,
    parameter int unsigned ROW_N  = L2_ROW_N,
    parameter int unsigned CH_N   = L2_CH_N,
    parameter int unsigned OUT_AW = L2_OUT_AW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ConvValid_i,
    input  logic              vbit_i,
    input  logic [DW-1:0]     ConvData_i,
    output logic              OutRamWe_o,
    output logic [OUT_AW-1:0] OutRamAddr_o,
    output logic [DW-1:0]     OutRamData_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              Err_o
);

    localparam int unsigned CW  = cnt_w(COL_N);
    localparam int unsigned RW  = cnt_w(ROW_N);
    localparam int unsigned CHW = cnt_w(CH_N);
    localparam int unsigned RBN = COL_N / 2;
    localparam int unsigned RBW = cnt_w(RBN);

    conv_state_e       state_q, state_nxt;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [CHW-1:0]    ch_q;
    logic [OUT_AW-1:0] wr_cnt_q;
    logic [DW-1:0]     hold_q;

    logic              acc_c, start_c, last_c, col_end_c, row_end_c;
    logic              rb_we_c, pool_c;
    logic [DW-1:0]     relu_c, hmax_c, vmax_c, rb_rd_c;
    logic [RBW-1:0]    rb_idx_c;

    // A sample counts only in RUN while the run is still enabled, so an abort
    // cycle cannot register a new write
    assign acc_c     = vbit_i && ConvValid_i && (state_q == ST_RUN);
    assign start_c   = (state_q == ST_IDLE) && ConvValid_i;
    assign col_end_c = (col_q == CW'(COL_N - 1));
    assign row_end_c = (row_q == RW'(ROW_N - 1));
    assign last_c    = col_end_c && row_end_c && (ch_q == CHW'(CH_N - 1));

    // ReLU, then horizontal and vertical max; unsigned compare is valid after ReLU
    assign relu_c   = ConvData_i[DW-1] ? '0 : ConvData_i;
    assign hmax_c   = (relu_c > hold_q) ? relu_c : hold_q;
    assign vmax_c   = (rb_rd_c > hmax_c) ? rb_rd_c : hmax_c;
    assign rb_idx_c = RBW'(col_q >> 1);
    assign rb_we_c  = acc_c && !row_q[0] && col_q[0];
    assign pool_c   = acc_c && row_q[0] && col_q[0];

    l2_pool_rowbuf #(
        .DW    (DW),
        .DEPTH (RBN),
        .AW    (RBW)
    ) u_rowbuf (
        .clk   (clk),
        .we    (rb_we_c),
        .waddr (rb_idx_c),
        .wdata (hmax_c),
        .raddr (rb_idx_c),
        .rdata (rb_rd_c)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: if (ConvValid_i) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!ConvValid_i)          state_nxt = ST_IDLE;
                else if (acc_c && last_c)  state_nxt = ST_DONE;
            end
            ST_DONE: if (!ConvValid_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            Busy_o  <= 1'b0;
            Done_o  <= 1'b0;
            Err_o   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            Busy_o  <= (state_nxt == ST_RUN);
            Done_o  <= (state_nxt == ST_DONE);
            if (vbit_i && (state_q != ST_RUN)) Err_o <= 1'b1;
            else if (start_c)                  Err_o <= 1'b0;
        end
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (start_c) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (acc_c) begin
            if (col_end_c) begin
                col_q <= '0;
                if (row_end_c) begin
                    row_q <= '0;
                    ch_q  <= (ch_q == CHW'(CH_N - 1)) ? '0 : ch_q + CHW'(1);
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Horizontal holding register and output RAM write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q       <= '0;
            wr_cnt_q     <= '0;
            OutRamWe_o   <= 1'b0;
            OutRamAddr_o <= '0;
            OutRamData_o <= '0;
        end else begin
            OutRamWe_o <= pool_c;
            if (acc_c && !col_q[0]) hold_q <= relu_c;
            if (start_c) begin
                wr_cnt_q <= '0;
            end else if (pool_c) begin
                OutRamData_o <= vmax_c;
                OutRamAddr_o <= wr_cnt_q;
                wr_cnt_q     <= wr_cnt_q + OUT_AW'(1);
            end
        end
    end

endmodule
